// File: rtl/icache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
// Holds the controller state encoding, the address-field widths and the stall fill word.
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int DEF_LINES = 32;
    localparam int DEF_WORDS = 8;

    // Byte address layout: {tag, index, offset, byte}
    localparam int OFF_W = $clog2(DEF_WORDS);
    localparam int IDX_W = $clog2(DEF_LINES);
    localparam int TAG_W = 15 - OFF_W - IDX_W;

    localparam logic [15:0] STALL_INSTR = 16'h0000;

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-port and memory-port signal bundle between the core/memory and the cache.
// The slave modport is the cache's own view of the bundle.
interface icache_ctrl_if;

    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_instr;
    logic        cpu_stall;
    logic        flush;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    modport slave (
        input  cpu_req, cpu_addr, flush, mem_rdata, mem_rvalid,
        output cpu_instr, cpu_stall, mem_req, mem_addr, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_addr, flush, mem_rdata, mem_rvalid,
        input  cpu_instr, cpu_stall, mem_req, mem_addr, hit_cnt, miss_cnt
    );

endinterface

// File: rtl/icache_data_array.sv
// Instruction storage: LINES x WORDS x 16 bits.
// One synchronous write port for line fills, one asynchronous read port for fetch hits.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(LINES)-1:0] i_widx,
    input  logic [$clog2(WORDS)-1:0] i_woff,
    input  logic [15:0]              i_wdata,
    input  logic [$clog2(LINES)-1:0] i_ridx,
    input  logic [$clog2(WORDS)-1:0] i_roff,
    output logic [15:0]              o_rdata
);

    logic [15:0] r_mem [LINES][WORDS];

    // NOTE: storage arrays get no reset (validity is tracked separately), and flops always use <=.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx][i_woff] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx][i_roff];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with an 8-word pipelined line-fill controller.
// Optional perf counters: define ICACHE_PERF_EN to enable hit_cnt/miss_cnt.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int LINES = DEF_LINES,
    parameter int WORDS = DEF_WORDS
) (
    input logic          clk,
    input logic          rst,
    icache_ctrl_if.slave bus
);

    localparam int W_OFF = $clog2(WORDS);
    localparam int W_IDX = $clog2(LINES);
    localparam int W_TAG = 15 - W_OFF - W_IDX;

    state_t             r_state;
    state_t             w_next;
    logic [LINES-1:0]   r_valid;
    logic [W_TAG-1:0]   r_tag [LINES];
    logic [W_TAG-1:0]   r_fill_tag;
    logic [W_IDX-1:0]   r_fill_idx;
    logic [W_OFF:0]     r_ic;
    logic [W_OFF-1:0]   r_rc;
    logic               r_mem_req;
    logic [15:0]        r_mem_addr;

    logic [W_OFF-1:0]   w_off;
    logic [W_IDX-1:0]   w_idx;
    logic [W_TAG-1:0]   w_tag;
    logic [15:0]        w_rdata;
    logic               w_hit;
    logic               w_miss;
    logic               w_fill_we;
    logic               w_last;
    logic               w_unused_addr0;

    assign w_off          = bus.cpu_addr[W_OFF:1];
    assign w_idx          = bus.cpu_addr[W_OFF+W_IDX:W_OFF+1];
    assign w_tag          = bus.cpu_addr[15:W_OFF+W_IDX+1];
    assign w_unused_addr0 = bus.cpu_addr[0];

    assign w_hit     = (r_state == IDLE) && bus.cpu_req && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss    = (r_state == IDLE) && bus.cpu_req && !w_hit;
    assign w_fill_we = (r_state == FILL) && bus.mem_rvalid;
    assign w_last    = w_fill_we && (r_rc == W_OFF'(WORDS - 1));

    icache_data_array #(.LINES(LINES), .WORDS(WORDS)) u_data (
        .clk     (clk),
        .i_we    (w_fill_we),
        .i_widx  (r_fill_idx),
        .i_woff  (r_rc),
        .i_wdata (bus.mem_rdata),
        .i_ridx  (w_idx),
        .i_roff  (w_off),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_miss) w_next = FILL;
            FILL:    if (w_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_instr = STALL_INSTR;
        bus.cpu_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) bus.cpu_instr = w_rdata;
                bus.cpu_stall = w_miss;
            end
            FILL:    bus.cpu_stall = 1'b1;
            default: bus.cpu_stall = 1'b0;
        endcase
    end

    // r_ic holds the offset of the next request; the first request is launched from the miss cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ic       <= '0;
            r_rc       <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_fill_tag <= '0;
            r_fill_idx <= '0;
        end else if (r_state == IDLE) begin
            r_mem_req <= 1'b0;
            if (w_miss) begin
                r_fill_tag <= w_tag;
                r_fill_idx <= w_idx;
                r_mem_req  <= 1'b1;
                r_mem_addr <= {w_tag, w_idx, {W_OFF{1'b0}}, 1'b0};
                r_ic       <= (W_OFF+1)'(1);
            end
        end else begin
            if (r_ic != (W_OFF+1)'(WORDS)) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= {r_fill_tag, r_fill_idx, r_ic[W_OFF-1:0], 1'b0};
                r_ic       <= r_ic + 1'b1;
            end else begin
                r_mem_req  <= 1'b0;
            end
            if (bus.mem_rvalid) r_rc <= r_rc + 1'b1;
            if (w_last)         r_ic <= '0;
        end
    end

    // A completing fill installs its line after any same-edge flush has cleared the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (bus.flush) r_valid <= '0;
            if (w_last)    r_valid[r_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_last) r_tag[r_fill_idx] <= r_fill_tag;
    end

    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_mem_addr;

`ifdef ICACHE_PERF_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && r_hit_cnt != 16'hFFFF)   r_hit_cnt  <= r_hit_cnt + 1'b1;
            if (w_miss && r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
`else
    assign bus.hit_cnt  = '0;
    assign bus.miss_cnt = '0;
`endif

endmodule
